// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encoding shared by alu_muldiv and its bench
package alu_pkg;
  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
  localparam logic [OP_W-1:0] OP_SLL    = 5'd2;
  localparam logic [OP_W-1:0] OP_SLT    = 5'd3;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR    = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL    = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA    = 5'd7;
  localparam logic [OP_W-1:0] OP_OR     = 5'd8;
  localparam logic [OP_W-1:0] OP_AND    = 5'd9;
  localparam logic [OP_W-1:0] OP_LUI    = 5'd10;
  localparam logic [OP_W-1:0] OP_MUL    = 5'd16;
  localparam logic [OP_W-1:0] OP_MULH   = 5'd17;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd18;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'd19;
  localparam logic [OP_W-1:0] OP_DIV    = 5'd20;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'd21;
  localparam logic [OP_W-1:0] OP_REM    = 5'd22;
  localparam logic [OP_W-1:0] OP_REMU   = 5'd23;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiply / restoring divide on magnitudes, first step taken on start, sign fixup on the done cycle
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  logic [XLEN-1:0] hi, lo, d, ma, mb, s_hi, s_lo, s_d, r;
  logic [CW-1:0] cnt;
  logic act, is_div, neg, sel_hi, a_sig, b_sig, sa, sb, s_div;
  logic [XLEN:0] sum, t, diff;
  logic [2*XLEN-1:0] nxt, p, pn;
  always_comb begin
    a_sig = !(op[0] & (op[1] | op[2]));
    b_sig = a_sig & (op != 3'd2);
    sa = a_sig & a[XLEN-1];
    sb = b_sig & b[XLEN-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    s_hi = start ? '0 : hi;
    s_lo = start ? (op[2] ? ma : mb) : lo;
    s_d = start ? (op[2] ? mb : ma) : d;
    s_div = start ? op[2] : is_div;
    sum = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_d} : '0);
    t = {s_hi, s_lo[XLEN-1]};
    diff = t - {1'b0, s_d};
    nxt = s_div ? {diff[XLEN] ? t[XLEN-1:0] : diff[XLEN-1:0], s_lo[XLEN-2:0], !diff[XLEN]} : {sum, s_lo[XLEN-1:1]};
    p = {hi, lo};
    pn = neg ? -p : p;
    r = sel_hi ? hi : lo;
    result = is_div ? (neg ? -r : r) : (sel_hi ? pn[2*XLEN-1:XLEN] : pn[XLEN-1:0]);
    done = act & (cnt == CW'(XLEN));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      d <= '0;
      is_div <= 1'b0;
      neg <= 1'b0;
      sel_hi <= 1'b0;
    end else if (start) begin
      act <= 1'b1;
      cnt <= CW'(1);
      {hi, lo} <= nxt;
      d <= s_d;
      is_div <= op[2];
      sel_hi <= op[2] ? op[1] : (op[1:0] != 2'd0);
      neg <= op[2] ? (op[1] ? sa : (sa ^ sb) & (b != '0)) : sa ^ sb;
    end else if (act && !done) begin
      cnt <= cnt + 1'b1;
      {hi, lo} <= nxt;
    end else begin
      act <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: IDLE/BUSY/DONE ALU with 1-cycle base ops and an iterative RV-M path present only when ALU_MULDIV_EN is defined
module alu_muldiv import alu_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              busy
);
  localparam int SW = $clog2(XLEN);
  state_t state, state_n;
  logic [OP_W-1:0] op;
  logic [SW-1:0] sh;
  logic [XLEN-1:0] base, md_res;
  logic acc, md, md_done;
  assign op = OP_W'(in_op);
  assign sh = in_b[SW-1:0];
  always_comb begin
    base = '0;
    case (op)
      OP_ADD:  base = in_a + in_b;
      OP_SUB:  base = in_a - in_b;
      OP_SLL:  base = in_a << sh;
      OP_SLT:  base = XLEN'($signed(in_a) < $signed(in_b));
      OP_SLTU: base = XLEN'(in_a < in_b);
      OP_XOR:  base = in_a ^ in_b;
      OP_SRL:  base = in_a >> sh;
      OP_SRA:  base = $signed(in_a) >>> sh;
      OP_OR:   base = in_a | in_b;
      OP_AND:  base = in_a & in_b;
      OP_LUI:  base = in_b;
      default: base = '0;
    endcase
  end
`ifdef ALU_MULDIV_EN
  assign md = op[4:3] == 2'b10;
  assign busy = state == S_BUSY;
  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk(clk),
    .rst_n(rst_n),
    .start(acc & md),
    .op(op[2:0]),
    .a(in_a),
    .b(in_b),
    .done(md_done),
    .result(md_res)
  );
`else
  assign md = 1'b0;
  assign busy = 1'b0;
  assign md_done = 1'b0;
  assign md_res = '0;
`endif
  assign in_ready = state == S_IDLE || (state == S_DONE && out_ready);
  assign acc = in_valid & in_ready;
  assign out_valid = state == S_DONE;
  always_comb begin
    state_n = acc ? (md ? S_BUSY : S_DONE) : (state == S_BUSY && md_done) ? S_DONE : (state == S_DONE && out_ready) ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      out_result <= '0;
    end else begin
      state <= state_n;
      out_result <= (acc && !md) ? base : md_done ? md_res : out_result;
    end
  end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits (legal: 8..64, even).
REQ-002 Parameter CTRL_W, default 5, width of the operation-select field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_op  input  CTRL_W  operation code, from package alu_pkg.
REQ-008 in_a  input  XLEN  Operand1.
REQ-009 in_b  input  XLEN  Operand2.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_result  output  XLEN  result value.
REQ-013 busy  output  1  iterative operation in progress.

Function
REQ-014 Accept = in_valid & in_ready; in_ready SHALL be 1 only in IDLE, or in DONE when out_ready is 1 (back-to-back).
REQ-015 States SHALL be IDLE, BUSY, DONE; IDLE->DONE on accept of a base op; IDLE->BUSY on accept of a mul/div op; BUSY->DONE after the final iteration; DONE->IDLE on out_ready without a new accept; DONE->DONE or DONE->BUSY on out_ready with a new accept.
REQ-016 Base ops SLL, SRL, SRA, ADD, SUB, XOR, OR, AND, SLT, SLTU, LUI SHALL be computed combinationally and registered: out_valid rises the cycle after accept (latency 1).
REQ-017 Shift amount SHALL be in_b[$clog2(XLEN)-1:0]; SLT/SLTU return 1 or 0, zero-extended; LUI returns in_b.
REQ-018 Mul/div ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU SHALL use RV-M semantics and latency exactly XLEN+1 cycles from accept to out_valid (XLEN radix-2 iterations plus one sign-fixup cycle).
REQ-019 MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product, with signed*signed, signed*unsigned, unsigned*unsigned operands respectively.
REQ-020 Divide by zero: DIV/DIVU SHALL return all ones; REM/REMU SHALL return in_a; latency unchanged.
REQ-021 Signed overflow (in_a = most-negative, in_b = -1): DIV SHALL return in_a; REM SHALL return 0.
REQ-022 Undefined op codes SHALL take the base path and return 0.
REQ-023 Operands and op SHALL be captured at accept; input changes afterwards SHALL NOT affect the result.
REQ-024 out_result and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 busy SHALL equal (state == BUSY).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, out_result 0, busy 0, iteration counter 0, in_ready 1 after release.
REQ-027 Reset asserted mid-iteration SHALL abandon the operation; no result SHALL be emitted for it.

Configuration
REQ-028 Macro ALU_MULDIV_EN defined: mul/div path and BUSY state SHALL be present per REQ-018..021.
REQ-029 Macro ALU_MULDIV_EN undefined: mul/div codes SHALL be treated as undefined (REQ-022, latency 1), and BUSY SHALL be unreachable, busy tied 0.

Structure
REQ-030 Package alu_pkg SHALL hold the CTRL_W-bit op-code constants (base codes unchanged from the existing ALU encoding, mul/div codes appended) and the state enumeration.
REQ-031 Iterative multiply/divide datapath SHALL be a sub-module muldiv_iter (start, op, operands in; done, result out), instantiated only under ALU_MULDIV_EN.

Verification
REQ-032 ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid the next cycle, out_result=0x80000000.
REQ-033 SRA a=0x80000000 b=0x00000024 -> shift 4, out_result=0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0.
REQ-034 MULH a=0x80000000 b=0x80000000 -> out_valid exactly 33 cycles after accept, out_result=0x40000000; MULHU same -> 0x40000000; MUL -> 0x00000000.
REQ-035 DIV a=7 b=0 -> 0xFFFFFFFF; REM a=7 b=0 -> 7; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV a=-7 b=2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-036 out_ready held 0 for 5 cycles after DIVU result -> result stable, in_ready 0; then out_ready=1 with new ADD in_valid=1 -> accepted same cycle, next result one cycle later.
REQ-037 rst_n pulsed low at cycle 10 of a DIVU -> out_valid never asserts for it, busy 0, next request completes normally.
